mcp_add_stream: RTL and testbench
=================================

# mcp_add_stream

Streaming front end for a wide adder constrained as a multicycle path. Upstream producers hand operands over a valid/ready handshake. The block holds the operand registers stable for CYCLES clock periods, captures the sum, and presents it on a valid/ready output with backpressure. It sits between a stream source and any consumer that needs WIDTH-bit sums at a clock rate the single-cycle adder cannot close.

## Interface
Parameters:
- WIDTH, 64: operand and sum width in bits; must be ≥ 2.
- CYCLES, 2: multicycle factor, i.e. clock periods allotted to the add; must be ≥ 1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands on in_a/in_b are valid.
- in_ready  out  1  block accepts operands this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- out_valid  out  1  out_sum holds a completed result.
- out_ready  in  1  consumer accepts the result this cycle.
- out_sum  out  WIDTH  registered result, a_r + b_r.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- The block registers operands a_r/b_r (WIDTH each), result sum_r, a down-counter cnt of width $clog2(CYCLES)+1, and a 3-state FSM with states IDLE, WAIT and HOLD.
- An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). It is combinational from state and out_ready.
- out_valid = (state==HOLD).
- IDLE: on an input transfer, load a_r←in_a, b_r←in_b, cnt←CYCLES-1, and go to WAIT.
- WAIT:
  - a_r/b_r are never written; in_ready=0.
  - If cnt==0: sum_r←a_r+b_r and go to HOLD.
  - Otherwise, decrement cnt.
- HOLD:
  - out_sum=sum_r is held stable until the output transfer.
  - On an output transfer with no simultaneous input transfer, go to IDLE.
  - On simultaneous output and input transfers, load a new a_r/b_r and cnt←CYCLES-1, and go to WAIT.
- Arithmetic: the sum is modulo 2^WIDTH; carry-out is discarded unless the Configuration macro is defined.
- Reset values: state=IDLE, cnt=0, a_r=b_r=sum_r=0. After reset, out_valid=0, out_sum=0, busy=0, in_ready=1.
- Reset mid-operation: the in-flight operation is dropped, no output transfer occurs, and the block is in IDLE on the first edge after rst deasserts.
- in_a/in_b changing while in WAIT has no effect on the result.

## Timing
- Input accepted at edge E → sum_r written at edge E+CYCLES → out_valid high from E+CYCLES until the consumer accepts.
- Minimum issue interval is CYCLES+1 cycles: back-to-back through HOLD with out_ready=1.
- The a_r/b_r → sum_r path carries a multicycle constraint: setup CYCLES, hold CYCLES-1. The FSM guarantees a_r/b_r are stable for edges E+1 … E+CYCLES.
- All other paths are single-cycle: in_ready/out_ready are combinational, and cnt and FSM are single-cycle.
- CYCLES=1 degenerates to a normal single-cycle registered adder with 1-cycle latency.

## Configuration
- MCP_ADD_STREAM_CARRY_EN defined:
  - Adds output port out_carry (1 bit), registered alongside sum_r from bit WIDTH of the (WIDTH+1)-bit add.
  - out_carry resets to 0, is held in HOLD, and is covered by the same multicycle constraint.
- Undefined: no out_carry port; the add is WIDTH bits and the carry is dropped.

## Test plan
- Reset mid-WAIT: WIDTH=64, CYCLES=2, accept a=5/b=7, assert rst one cycle later → out_valid stays 0; after release, in_ready=1, busy=0, out_sum=0.
- Basic latency: CYCLES=2, accept a=0x0000_0001_FFFF_FFFF, b=1 at edge E → out_valid rises at E+2 with out_sum=0x0000_0002_0000_0000; in_ready=0 at E+1.
- Wrap-around: a=0xFFFF_FFFF_FFFF_FFFF, b=2 → out_sum=1. With MCP_ADD_STREAM_CARRY_EN defined, out_carry=1.
- Backpressure: out_ready=0 for 5 cycles after result 42 → out_sum stays 42, out_valid stays 1, in_ready stays 0, and new in_a/in_b are ignored.
- Back-to-back: out_ready=1, in_valid held high with 4 operand pairs, CYCLES=3 → one result every 4 cycles, in order, with correct sums.
- Stability under input churn: randomize in_a/in_b every cycle during WAIT → result equals the operands captured at acceptance.

Source files
------------

// File: rtl/mcp_add_stream.sv
// mcp_add_stream: valid/ready front end for a WIDTH-bit adder constrained as a
// CYCLES-cycle multicycle path. Operands are captured on input acceptance and
// held stable while the add settles; the sum is then held until the consumer
// takes it.
// Optional feature: define MCP_ADD_STREAM_CARRY_EN to add the out_carry port
// (bit WIDTH of the widened add, registered with the sum).
module mcp_add_stream #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
`ifdef MCP_ADD_STREAM_CARRY_EN
    output logic             out_carry,
`endif
    output logic             busy
);

    localparam int unsigned      CNT_W    = $clog2(CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
`ifdef MCP_ADD_STREAM_CARRY_EN
    logic             carry_q;
    logic             carry_d;
    logic [WIDTH:0]   sum_full_d;
`endif

    logic in_xfer_c;
    logic out_xfer_c;
    logic capture_c;

    // Handshake decode; in_ready is combinational from state and out_ready.
    always_comb begin
        in_ready   = 1'b0;
        in_xfer_c  = 1'b0;
        out_xfer_c = 1'b0;
        capture_c  = 1'b0;
        in_ready   = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
        in_xfer_c  = in_valid && in_ready;
        out_xfer_c = (state_q == ST_HOLD) && out_ready;
        capture_c  = (state_q == ST_WAIT) && (cnt_q == '0);
    end

    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q != ST_IDLE);
    assign out_sum   = sum_q;

`ifdef MCP_ADD_STREAM_CARRY_EN
    // Multicycle adder: widened by one bit so the carry-out is kept.
    always_comb begin
        sum_full_d = '0;
        sum_full_d = {1'b0, a_q} + {1'b0, b_q};
        sum_d      = sum_full_d[WIDTH-1:0];
        carry_d    = sum_full_d[WIDTH];
    end

    assign out_carry = carry_q;
`else
    // Multicycle adder: modulo 2^WIDTH, carry-out dropped.
    always_comb begin
        sum_d = '0;
        sum_d = a_q + b_q;
    end
`endif

    // Control FSM: accept, count down the settle window, hold the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_xfer_c) begin
                        cnt_q   <= CNT_LOAD;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (out_xfer_c) begin
                        if (in_xfer_c) begin
                            cnt_q   <= CNT_LOAD;
                            state_q <= ST_WAIT;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Operand registers: written only on acceptance, so they stay stable in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (in_xfer_c) begin
            a_q <= in_a;
            b_q <= in_b;
        end
    end

    // Result register: captured at the end of the settle window, held in HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if (capture_c) begin
            sum_q <= sum_d;
        end
    end

`ifdef MCP_ADD_STREAM_CARRY_EN
    // Carry register: captured together with the sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else if (capture_c) begin
            carry_q <= carry_d;
        end
    end
`endif

endmodule

// File: tb/tb_mcp_add_stream.sv
// Directed bench for mcp_add_stream with a scoreboard: one instance at CYCLES=2
// and one at CYCLES=3 (back-to-back issue interval).
module tb_mcp_add_stream;

    localparam int unsigned W = 64;

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         iv2, ir2, ov2, or2, bz2, c2;
    logic [W-1:0] a2, b2, s2;
    logic         iv3, ir3, ov3, or3, bz3, c3;
    logic [W-1:0] a3, b3, s3;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit xfer3    = 1'b0;
    exp_t q2[$];
    exp_t q3[$];
    int   out_cyc3[$];

    mcp_add_stream #(.WIDTH(W), .CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(iv2), .in_ready(ir2), .in_a(a2), .in_b(b2),
        .out_valid(ov2), .out_ready(or2), .out_sum(s2),
`ifdef MCP_ADD_STREAM_CARRY_EN
        .out_carry(c2),
`endif
        .busy(bz2)
    );

    mcp_add_stream #(.WIDTH(W), .CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .in_valid(iv3), .in_ready(ir3), .in_a(a3), .in_b(b3),
        .out_valid(ov3), .out_ready(or3), .out_sum(s3),
`ifdef MCP_ADD_STREAM_CARRY_EN
        .out_carry(c3),
`endif
        .busy(bz3)
    );

`ifndef MCP_ADD_STREAM_CARRY_EN
    assign c2 = 1'b0;
    assign c3 = 1'b0;
`endif

    function automatic exp_t mk(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [W:0] full;
        full    = {1'b0, a} + {1'b0, b};
        e.sum   = full[W-1:0];
        e.carry = full[W];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: settle, score handshakes seen before the edge, advance.
    task automatic step();
        exp_t e;
        #1;
        xfer3 = 1'b0;
        if (ov2 && or2) begin
            chk("sb2_pending", (W+1)'(q2.size() != 0), 1);
            if (q2.size() != 0) begin
                e = q2.pop_front();
                chk("sb2_sum", s2, e.sum);
`ifdef MCP_ADD_STREAM_CARRY_EN
                chk("sb2_carry", c2, e.carry);
`endif
            end
        end
        if (iv2 && ir2) q2.push_back(mk(a2, b2));
        if (ov3 && or3) begin
            out_cyc3.push_back(cyc);
            chk("sb3_pending", (W+1)'(q3.size() != 0), 1);
            if (q3.size() != 0) begin
                e = q3.pop_front();
                chk("sb3_sum", s3, e.sum);
            end
        end
        if (iv3 && ir3) begin
            q3.push_back(mk(a3, b3));
            xfer3 = 1'b1;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic wait_valid2(input string tag);
        for (int i = 0; i < 10 && !ov2; i++) step();
        chk(tag, ov2, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] pa [4];
        logic [W-1:0] pb [4];
        int idx;

        rst = 1'b1;
        iv2 = 0; or2 = 0; a2 = '0; b2 = '0;
        iv3 = 0; or3 = 0; a3 = '0; b3 = '0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        // Reset state
        chk("rst_out_valid", ov2, 0);
        chk("rst_out_sum", s2, 0);
        chk("rst_busy", bz2, 0);
        chk("rst_in_ready", ir2, 1);
        chk("rst_in_ready3", ir3, 1);

        // Reset mid-WAIT drops the operation
        iv2 = 1; a2 = 64'd5; b2 = 64'd7;
        step();
        iv2 = 0;
        chk("rmw_busy", bz2, 1);
        step();
        rst = 1'b1;
        q2.delete();
        #1;
        chk("rmw_valid_in_rst", ov2, 0);
        repeat (2) begin
            step();
            chk("rmw_valid_hold", ov2, 0);
        end
        rst = 1'b0;
        step();
        chk("rmw_out_valid", ov2, 0);
        chk("rmw_in_ready", ir2, 1);
        chk("rmw_busy_after", bz2, 0);
        chk("rmw_out_sum", s2, 0);

        // Basic latency: out_valid rises exactly CYCLES edges after acceptance
        or2 = 1;
        iv2 = 1; a2 = 64'h0000_0001_FFFF_FFFF; b2 = 64'd1;
        step();
        iv2 = 0;
        chk("lat_in_ready_e", ir2, 0);
        chk("lat_valid_e", ov2, 0);
        step();
        chk("lat_in_ready_e1", ir2, 0);
        chk("lat_valid_e1", ov2, 0);
        step();
        chk("lat_valid_e2", ov2, 1);
        chk("lat_sum_e2", s2, 64'h0000_0002_0000_0000);
        step();
        chk("lat_drained", ov2, 0);
        chk("lat_idle", bz2, 0);

        // Wrap-around
        iv2 = 1; a2 = 64'hFFFF_FFFF_FFFF_FFFF; b2 = 64'd2;
        step();
        iv2 = 0;
        wait_valid2("wrap_valid");
        chk("wrap_sum", s2, 1);
`ifdef MCP_ADD_STREAM_CARRY_EN
        chk("wrap_carry", c2, 1);
`endif
        step();

        // Backpressure holds the result and blocks new operands
        or2 = 0;
        iv2 = 1; a2 = 64'd40; b2 = 64'd2;
        step();
        wait_valid2("bp_valid");
        for (int i = 0; i < 5; i++) begin
            iv2 = 1; a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
            step();
            chk("bp_out_valid", ov2, 1);
            chk("bp_out_sum", s2, 64'd42);
            chk("bp_in_ready", ir2, 0);
        end
        iv2 = 0; or2 = 1;
        step();
        chk("bp_drained", ov2, 0);

        // Stability under input churn during WAIT
        or2 = 0;
        for (int t = 0; t < 3; t++) begin
            iv2 = 1; a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
            step();
            repeat (2) begin
                a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
                step();
            end
            iv2 = 0;
            chk("churn_valid", ov2, 1);
            or2 = 1;
            step();
            or2 = 0;
        end

        // Back-to-back at CYCLES=3: one result every CYCLES+1 cycles
        pa[0] = 64'd1;                  pb[0] = 64'd2;
        pa[1] = 64'hFFFF_FFFF_FFFF_FFFF; pb[1] = 64'd1;
        pa[2] = 64'h1234_5678_9ABC_DEF0; pb[2] = 64'h0FED_CBA9_8765_4321;
        pa[3] = 64'h8000_0000_0000_0000; pb[3] = 64'h7FFF_FFFF_FFFF_FFFF;
        or3 = 1;
        idx = 0;
        out_cyc3.delete();
        for (int i = 0; i < 40 && out_cyc3.size() < 4; i++) begin
            if (idx < 4) begin
                iv3 = 1; a3 = pa[idx]; b3 = pb[idx];
            end else begin
                iv3 = 0; a3 = {$urandom, $urandom}; b3 = {$urandom, $urandom};
            end
            step();
            if (xfer3) idx++;
        end
        iv3 = 0;
        chk("b2b_count", (W+1)'(out_cyc3.size()), 4);
        for (int k = 1; k < out_cyc3.size(); k++)
            chk("b2b_interval", (W+1)'(out_cyc3[k] - out_cyc3[k-1]), 4);

        // Nothing left outstanding
        step();
        chk("sb2_empty", (W+1)'(q2.size()), 0);
        chk("sb3_empty", (W+1)'(q3.size()), 0);
        chk("end_busy3", bz3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
